// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 UART transmitter with a one-byte holding register, LSB first
module uart_tx #(
    parameter int CLK_DIV   = 434,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] din,
    input  logic       din_val,
    output logic       din_rdy,
    output logic       txd,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          sidx;
    logic [7:0]    hold;
    logic [7:0]    shifter;
    logic          full;
    logic          accept;
    logic          bit_end;
    logic          last_stop;
    logic          load;

    // din_rdy doubles as the inverted holding-full flag
    assign full      = !din_rdy;
    assign accept    = din_val && din_rdy;
    assign bit_end   = cnt == CW'(CLK_DIV - 1);
    assign last_stop = (STOP_BITS == 1) || sidx;
    // holding byte moves to the shifter from IDLE, or straight out of the final stop bit
    assign load      = full && (state == IDLE || (state == STOP && bit_end && last_stop));

    // handshake, baud counter and frame FSM; outputs are set together with the state they belong to
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            sidx    <= 1'b0;
            hold    <= '0;
            shifter <= '0;
            din_rdy <= 1'b1;
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            if (accept) hold <= din;
            din_rdy <= accept ? 1'b0 : (load ? 1'b1 : din_rdy);
            cnt     <= (state == IDLE || bit_end) ? '0 : cnt + 1'b1;
            tx_done <= state == STOP && last_stop && cnt == CW'(CLK_DIV - 2);
            if (load) begin
                shifter <= hold;
                state   <= START;
                txd     <= 1'b0;
                tx_busy <= 1'b1;
            end else begin
                case (state)
                    START: if (bit_end) begin
                        state <= DATA;
                        idx   <= '0;
                        txd   <= shifter[0];
                    end
                    DATA: if (bit_end) begin
                        shifter <= shifter >> 1;
                        idx     <= idx + 1'b1;
                        txd     <= (idx == 3'd7) ? 1'b1 : shifter[1];
                        if (idx == 3'd7) begin
                            state <= STOP;
                            sidx  <= 1'b0;
                        end
                    end
                    STOP: if (bit_end) begin
                        if (last_stop) begin
                            state   <= IDLE;
                            tx_busy <= 1'b0;
                        end else begin
                            sidx <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitter configurations checked every cycle against a frame-queue model
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic [7:0] din [3];
    logic       dv  [3];
    logic       run = 1'b0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s t=%0t got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // instance 0: CLK_DIV=4 8N1, instance 1: CLK_DIV=4 8N2, instance 2: CLK_DIV=434 8N1
    for (genvar g = 0; g < 3; g++) begin : u
        localparam int CD = (g == 2) ? 434 : 4;
        localparam int SB = (g == 1) ? 2 : 1;
        logic        rdy, txd, busy, done;
        logic [2:0]  q[$];
        logic [2:0]  m_exp;
        logic        m_full, m_rdy, m_acc, m_xfer;
        logic [7:0]  m_hold;
        logic [10:0] m_frame;

        uart_tx #(.CLK_DIV(CD), .STOP_BITS(SB)) dut (
            .clk(clk), .n_rst(n_rst), .din(din[g]), .din_val(dv[g]),
            .din_rdy(rdy), .txd(txd), .tx_busy(busy), .tx_done(done)
        );

        // model: q holds {txd,busy,done} for the current and future cycles; empty means idle line
        always @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                q.delete();
                m_full = 1'b0;
                m_rdy  = 1'b1;
                m_exp  = 3'b100;
            end else begin
                m_acc = dv[g] && m_rdy;
                if (q.size() > 0) void'(q.pop_front());
                m_xfer = q.size() == 0 && m_full;
                if (m_xfer) begin
                    m_frame = {2'b11, m_hold, 1'b0};
                    for (int k = 0; k < 9 + SB; k++)
                        for (int j = 0; j < CD; j++)
                            q.push_back({m_frame[k], 1'b1, (k == 8 + SB) && (j == CD - 1)});
                end
                if (m_acc) m_hold = din[g];
                m_full = m_acc || (m_full && !m_xfer);
                m_rdy  = !m_full;
                m_exp  = q.size() > 0 ? q[0] : 3'b100;
            end
        end
    end

    // compare every instance against its model on every falling edge
    always @(negedge clk) begin
        if (run) begin
            chk("txd0", u[0].txd, u[0].m_exp[2]);
            chk("busy0", u[0].busy, u[0].m_exp[1]);
            chk("done0", u[0].done, u[0].m_exp[0]);
            chk("rdy0", u[0].rdy, u[0].m_rdy);
            chk("txd1", u[1].txd, u[1].m_exp[2]);
            chk("busy1", u[1].busy, u[1].m_exp[1]);
            chk("done1", u[1].done, u[1].m_exp[0]);
            chk("rdy1", u[1].rdy, u[1].m_rdy);
            chk("txd2", u[2].txd, u[2].m_exp[2]);
            chk("busy2", u[2].busy, u[2].m_exp[1]);
            chk("done2", u[2].done, u[2].m_exp[0]);
            chk("rdy2", u[2].rdy, u[2].m_rdy);
        end
    end

    initial begin
        logic [9:0]  f55;
        logic [10:0] fff;
        logic [7:0]  seq [3];
        int          first, second, n, nd, dense;
        int          tdone [3];
        logic        acc_pending;
        f55 = 10'h2AA;
        fff = 11'h7FE;
        seq[0] = 8'h33;
        seq[1] = 8'h41;
        seq[2] = 8'h0D;
        for (int i = 0; i < 3; i++) begin
            din[i] = 8'h00;
            dv[i]  = 1'b0;
        end
        #1 n_rst = 1'b0;
        run = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("rst_txd", i == 0 ? u[0].txd : i == 1 ? u[1].txd : u[2].txd, 1);
            chk("rst_rdy", i == 0 ? u[0].rdy : i == 1 ? u[1].rdy : u[2].rdy, 1);
            chk("rst_busy", i == 0 ? u[0].busy : i == 1 ? u[1].busy : u[2].busy, 0);
        end
        n_rst = 1'b1;
        @(negedge clk);

        // single frames: 0x55 on 8N1, 0xFF on 8N2
        din[0] = 8'h55;
        din[1] = 8'hFF;
        dv[0]  = 1'b1;
        dv[1]  = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        dv[1] = 1'b0;
        chk("acc_rdy", u[0].rdy, 0);
        chk("acc_txd", u[0].txd, 1);
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (c == 1) chk("start_rdy", u[0].rdy, 1);
            if (c <= 40) begin
                chk("f55_txd", u[0].txd, f55[(c - 1) / 4]);
                chk("f55_done", u[0].done, c == 40);
                chk("f55_busy", u[0].busy, 1);
            end else chk("f55_idle", u[0].busy, 0);
            if (c <= 44) begin
                chk("fff_txd", u[1].txd, fff[(c - 1) / 4]);
                chk("fff_done", u[1].done, c == 44);
                chk("fff_busy", u[1].busy, 1);
            end else chk("fff_idle", u[1].busy, 0);
        end

        // back-to-back 0xA3, 0x0F with din_val held, plus an ignored byte while not ready
        din[0] = 8'hA3;
        dv[0]  = 1'b1;
        @(negedge clk);
        din[0] = 8'h0F;
        chk("b2b_hold", u[0].rdy, 0);
        @(negedge clk);
        chk("b2b_rdy", u[0].rdy, 1);
        chk("b2b_fall", u[0].txd, 0);
        @(negedge clk);
        dv[0] = 1'b0;
        chk("b2b_acc2", u[0].rdy, 0);
        first  = -1;
        second = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (c == 5) begin
                din[0] = 8'hEE;
                dv[0]  = 1'b1;
            end
            if (c == 6) dv[0] = 1'b0;
            if (c == 36) chk("b2b_wait", u[0].rdy, 0);
            if (c == 38) begin
                chk("b2b_next_rdy", u[0].rdy, 1);
                chk("b2b_nogap", u[0].txd, 0);
            end
            if (u[0].done) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
        end
        chk("b2b_first", first, 37);
        chk("b2b_gap", second - first, 40);

        // reset in the middle of data bit 3 of 0x00
        din[0] = 8'h00;
        dv[0]  = 1'b1;
        @(negedge clk);
        dv[0] = 1'b0;
        @(negedge clk);
        repeat (17) @(negedge clk);
        chk("mid_txd", u[0].txd, 0);
        chk("mid_busy", u[0].busy, 1);
        #2 n_rst = 1'b0;
        #1;
        chk("arst_txd", u[0].txd, 1);
        chk("arst_busy", u[0].busy, 0);
        chk("arst_rdy", u[0].rdy, 1);
        chk("arst_done", u[0].done, 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_rst_txd", u[0].txd, 1);
            chk("post_rst_busy", u[0].busy, 0);
        end

        // "3A\r" at full baud divisor, din_val held while bytes remain
        n  = 0;
        nd = 0;
        din[2] = seq[0];
        dv[2]  = 1'b1;
        acc_pending = dv[2] && u[2].rdy;
        for (int c = 0; c < 13100; c++) begin
            @(negedge clk);
            if (acc_pending) begin
                n++;
                if (n < 3) din[2] = seq[n];
                else dv[2] = 1'b0;
            end
            acc_pending = dv[2] && u[2].rdy;
            if (u[2].done) begin
                if (nd < 3) tdone[nd] = c;
                nd++;
            end
        end
        chk("slow_accepts", n, 3);
        chk("slow_frames", nd, 3);
        chk("slow_first", tdone[0], 4340);
        chk("slow_gap1", tdone[1] - tdone[0], 4340);
        chk("slow_gap2", tdone[2] - tdone[1], 4340);

        // randomized traffic with varying din_val density
        dense = 0;
        for (int c = 0; c < 8000; c++) begin
            @(negedge clk);
            if (c % 400 == 0) dense = $urandom_range(0, 7);
            for (int i = 0; i < 3; i++) begin
                din[i] = 8'($urandom);
                dv[i]  = $urandom_range(0, 7) <= dense;
            end
        end
        for (int i = 0; i < 3; i++) dv[i] = 1'b0;
        repeat (60) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the HEX calculator datapath. It serialises 8-bit result/echo bytes onto the TX line as 8N1 (or 8N2) frames, LSB first, at 115200 baud from the 50 MHz system clock. It is the transmit counterpart of the UART receiver and uses the same baud divisor. A one-entry holding register lets the calculator queue the next byte while the current frame is on the line.

Parameters:
CLK_DIV, 434, clk cycles per bit (50 MHz / 115200, rounded); minimum legal value 2.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  in  1  system clock, 50 MHz.
n_rst  in  1  asynchronous reset, active-low.
din  in  8  byte to transmit.
din_val  in  1  din is valid; the byte is accepted on a rising edge where din_val=1 and din_rdy=1.
din_rdy  out  1  holding register empty; can accept a byte.
txd  out  1  serial output; idle and stop level is 1.
tx_busy  out  1  high while the FSM is in any state other than IDLE.
tx_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame):
  - txd=1, din_rdy=1, tx_busy=0, tx_done=0.
  - Holding register cleared to empty; FSM in IDLE; all counters 0.
  - A partially sent frame is abandoned. No resume after reset.
- Registered outputs: txd, tx_done and tx_busy are registered. din_rdy is the registered negation of the holding-full flag. The block has no combinational input-to-output path.
- Handshake:
  - On an accept edge, din is copied into the holding register and holding-full is set.
  - While holding-full=1, din_rdy=0 and din_val is ignored.
  - din may change freely once the byte has been accepted.
- Baud counter:
  - Counts 0..CLK_DIV-1, then wraps. It is reset to 0 on every bit entry.
  - The last counter cycle of a bit is called bit_end.
  - Every bit lasts exactly CLK_DIV cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If holding-full, then at the next edge: shifter <= holding, holding-full cleared, go to START.
  - START: txd=0 for CLK_DIV cycles. At bit_end go to DATA with bit index=0.
  - DATA: txd=shifter[0]. At bit_end the shifter shifts right by 1 and the index increments. After index 7 reaches bit_end, go to STOP.
  - STOP: txd=1 for STOP_BITS*CLK_DIV cycles. tx_done=1 in the last cycle of the last stop bit. At that edge:
    - if holding-full: load the shifter, clear holding-full and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Latency: a byte accepted at edge N while in IDLE with holding empty gives:
  - holding-full=1 after edge N;
  - START entered at edge N+1, so txd falls after edge N+1;
  - din_rdy returns to 1 after edge N+1.
- Frame length is (9+STOP_BITS)*CLK_DIV cycles, measured from txd falling to the end of the last stop bit.
- Simultaneous events:
  - Holding transfer and new accept cannot coincide, because din_rdy=0 whenever holding is full.
  - An accept in the same cycle as the STOP→IDLE transition is legal: the byte starts from IDLE one cycle later, giving exactly one idle cycle (txd=1) between frames.
- Throughput: with din_val held high continuously, frames are contiguous (zero idle cycles). At most one byte is waiting while one is being shifted.

Test Plan:
1. CLK_DIV=4, STOP_BITS=1, send 0x55 → txd low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. tx_done pulses once, in cycle 40 after txd falls. tx_busy=1 throughout the frame.
2. CLK_DIV=4, back-to-back 0xA3 then 0x0F with din_val held high:
   - second byte accepted the cycle after the first leaves holding; din_rdy=0 until the second frame starts;
   - the 0x0F start bit immediately follows the 0xA3 stop bit (no gap);
   - two tx_done pulses, 40 cycles apart.
3. CLK_DIV=4, STOP_BITS=2, send 0xFF → start 4 cycles low, 32 cycles high data, 8 cycles high stop. tx_done at cycle 44; tx_busy falls after it.
4. CLK_DIV=4, send 0x00, assert n_rst=0 during DATA bit 3 → txd=1, tx_busy=0, din_rdy=1 immediately. After release, txd stays 1 with no frame output until a new byte is accepted.
5. CLK_DIV=434, send ASCII "3A\r" (0x33, 0x41, 0x0D), loopback into the UART receiver → the receiver outputs 0x33, 0x41, 0x0D in order. Each frame is 4340 cycles ±0.
6. CLK_DIV=4, din_val pulsed while din_rdy=0 with a different din → that byte is ignored and the transmitted sequence is unchanged.
